// File: rtl/ed_pkg.sv
// Shared widths, FSM state type and helpers for the energy-of-derivative channel scheduler.
package ed_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned DIFF_W   = 17;
  localparam int unsigned SQ_W     = 34;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ed_core.sv
// Three-stage difference / square / scale-and-saturate pipeline shared by all channels.
// The channel tag and valid bit ride alongside the data, one register per stage.
module ed_core
  import ed_pkg::*;
#(
  parameter int unsigned CH_W     = 2,
  parameter int unsigned OUT_BITS = 29,
  parameter int unsigned SCALE_SH = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_a,
  input  logic [SAMPLE_W-1:0] in_b,
  input  logic [CH_W-1:0]     in_ch,
  input  logic                in_last,
  output logic                out_valid,
  output logic [CH_W-1:0]     out_ch,
  output logic                out_last,
  output logic [OUT_BITS-1:0] out_data
);

  logic [DIFF_W-1:0]   diff_q;
  logic [SQ_W-1:0]     sq_q, sq_d;
  logic [SQ_W-1:0]     scaled;
  logic [OUT_BITS-1:0] sat_d;
  logic                v1_q, v2_q, last1_q, last2_q;
  logic [CH_W-1:0]     ch1_q, ch2_q;
  logic signed [SQ_W-1:0] diff_ext;

  // Sign-extend before multiplying so the product is computed at full width.
  always_comb begin
    diff_ext = SQ_W'($signed(diff_q));
    sq_d     = SQ_W'(diff_ext * diff_ext);
  end

  always_comb begin
    scaled = sq_q >> SCALE_SH;
    sat_d  = ((scaled >> OUT_BITS) != '0) ? '1 : scaled[OUT_BITS-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q    <= '0;
      sq_q      <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      last1_q   <= 1'b0;
      last2_q   <= 1'b0;
      ch1_q     <= '0;
      ch2_q     <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      diff_q    <= {in_a[SAMPLE_W-1], in_a} - {in_b[SAMPLE_W-1], in_b};
      v1_q      <= in_valid;
      ch1_q     <= in_ch;
      last1_q   <= in_last;
      sq_q      <= sq_d;
      v2_q      <= v1_q;
      ch2_q     <= ch1_q;
      last2_q   <= last1_q;
      out_data  <= v2_q ? sat_d : '0;
      out_valid <= v2_q;
      out_ch    <= v2_q ? ch2_q : '0;
      out_last  <= v2_q & last2_q;
    end
  end

endmodule

// File: rtl/ed_channel_scheduler.sv
// Accepts one multichannel frame, keeps per-channel sample history and issues the
// channels one per cycle into the shared ed_core pipeline.
module ed_channel_scheduler
  import ed_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned K_DELAY  = 2,
  parameter int unsigned OUT_BITS = 29,
  parameter int unsigned SCALE_SH = 1,
  localparam int unsigned CH_W    = ch_width(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SAMPLE_W*N_CH-1:0] in_data,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic [OUT_BITS-1:0]      out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic [15:0]              frame_cnt
);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_idx_q;
  logic                wait_q;
  logic [15:0]         frame_cnt_q;
  logic [SAMPLE_W-1:0] frame_q [N_CH];
  logic [SAMPLE_W-1:0] hist_q  [N_CH][K_DELAY];
  logic                accept;
  logic                issue_valid;
  logic                issue_last;
  logic [SAMPLE_W-1:0] op_a, op_b;

  assign accept     = in_valid && in_ready;
  assign issue_last = (ch_idx_q == CH_W'(N_CH - 1));
  assign op_a       = frame_q[ch_idx_q];
  assign op_b       = hist_q[ch_idx_q][K_DELAY-1];
  assign frame_cnt  = frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StIssue;
      StIssue: if (issue_last) state_d = StWait;
      StWait:  if (wait_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == StIdle);
    busy        = !in_ready;
    issue_valid = (state_q == StIssue);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_idx_q    <= '0;
      wait_q      <= 1'b0;
      frame_cnt_q <= '0;
      for (int c = 0; c < N_CH; c++) begin
        frame_q[c] <= '0;
        for (int j = 0; j < K_DELAY; j++) hist_q[c][j] <= '0;
      end
    end else begin
      // Second WAIT cycle is the one where wait_q is already set.
      wait_q <= (state_q == StWait) && !wait_q;
      if (accept) begin
        ch_idx_q    <= '0;
        frame_cnt_q <= frame_cnt_q + 16'd1;
        for (int c = 0; c < N_CH; c++) frame_q[c] <= in_data[SAMPLE_W*c +: SAMPLE_W];
      end
      if (issue_valid) begin
        ch_idx_q <= ch_idx_q + CH_W'(1);
        for (int j = K_DELAY - 1; j > 0; j--) hist_q[ch_idx_q][j] <= hist_q[ch_idx_q][j-1];
        hist_q[ch_idx_q][0] <= op_a;
      end
    end
  end

  ed_core #(
    .CH_W     (CH_W),
    .OUT_BITS (OUT_BITS),
    .SCALE_SH (SCALE_SH)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (issue_valid),
    .in_a      (op_a),
    .in_b      (op_b),
    .in_ch     (ch_idx_q),
    .in_last   (issue_last),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .out_data  (out_data)
  );

endmodule

// File: doc/ed_channel_scheduler.md
# ed_channel_scheduler

Time-multiplexes one pipelined energy-of-derivative datapath across `N_CH` recording channels. Accepts one frame (one signed 16-bit sample per channel), keeps per-channel sample history, issues the channels to the shared core one per cycle, and emits tagged per-channel results. It sits between the multichannel front-end sample bus and the downstream threshold/spike-detection logic.

## Interface
- `N_CH`, 4: channels per frame (≥2)
- `K_DELAY`, 2: derivative distance k in frames (≥1)
- `OUT_BITS`, 29: unsigned result width (≤33)
- `SCALE_SH`, 1: right shift applied to the squared difference
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  frame present on `in_data`
- `in_ready`  out  1  scheduler can accept a frame
- `in_data`  in  16*N_CH  channel c signed sample at [16c+15:16c]
- `out_valid`  out  1  result valid, single-cycle pulse per channel
- `out_ch`  out  max(1,$clog2(N_CH))  channel index of `out_data`
- `out_data`  out  OUT_BITS  saturated (x[n]−x[n−k])² >> SCALE_SH
- `out_last`  out  1  high with `out_valid` for channel N_CH−1
- `busy`  out  1  state ≠ IDLE
- `frame_cnt`  out  16  frames accepted, wraps 0xFFFF→0

## Operation
- States: IDLE, ISSUE, WAIT. `in_ready` = (state == IDLE); `busy` = !in_ready.
- IDLE: on `in_valid && in_ready` latch `in_data` into frame register, `ch_idx`←0, `frame_cnt`++, go ISSUE. `in_valid` outside IDLE is ignored; no frame is queued.
- ISSUE: core operands a = frame[ch_idx], b = hist[ch_idx][K_DELAY−1]; tag = {ch_idx, ch_idx==N_CH−1}. Same edge: hist[ch_idx][j]←hist[ch_idx][j−1], hist[ch_idx][0]←frame[ch_idx]. `ch_idx`++; after issuing N_CH−1 go WAIT.
- WAIT: 2-cycle counter, then IDLE.
- Core: stage1 diff = a − b (17-bit signed); stage2 sq = diff·diff (34-bit); stage3 s = sq >> SCALE_SH, `out_data` = s[33:OUT_BITS]≠0 ? all-ones : s[OUT_BITS−1:0]. Tag and issue-valid travel alongside, one register per stage.
- History is per channel, advances once per accepted frame; first K_DELAY frames compare against zero.
- No output backpressure; consumer must take every `out_valid` pulse.
- Reset (any time, including mid-frame): all outputs 0, `in_ready` 1 after release, state IDLE, history/frame/pipeline/`frame_cnt` cleared; in-flight results discarded, no `out_valid` after release.

## Timing
- Accept at edge e0. Channel c issued during cycle after e0+c; `out_valid` for channel c high in the cycle after edge e0+c+3. Latency 3 cycles, channels in ascending order on consecutive cycles.
- Last result registered at e0+N_CH+2; IDLE entered same edge, so `in_ready` rises together with `out_last`. Next accept at earliest edge e0+N_CH+3 → frame period N_CH+3 cycles.
- `frame_cnt` updates on the accept edge.

## Structure
- Package `ed_pkg`: SAMPLE_W=16, DIFF_W=17, SQ_W=34, state enum {IDLE, ISSUE, WAIT}, channel-index width function.
- Sub-module `ed_core`: 3-stage diff/square/scale-saturate pipeline with pass-through tag and valid; scheduler owns FSM, frame register, history arrays, counters.

## Test plan
- Reset release, idle: `in_ready`=1, `out_valid`=0, `frame_cnt`=0, all outputs 0.
- Frames ch0 = 100, 40, 70 (others 0), K_DELAY=2, SCALE_SH=1 → ch0 outputs 5000, 800, 450; other channels 0; `out_ch` 0..3 in order, `out_last` on ch3 only.
- Frame ch1=32767, then frame(s) with ch1=−32768 at distance k → ch1 result saturates to 536870911 (2²⁹−1); ch1=−32768 vs 0 → 536870911 too.
- `in_valid` held high continuously → accepts exactly every 7 cycles (N_CH=4), `out_valid` at accept+3..+6, `in_ready` rises with `out_last`, `frame_cnt` counts accepts only.
- Assert `rst_n` low during ISSUE of channel 2 → outputs 0 asynchronously, no stale `out_valid` after release; next frame ch0=100 yields 5000 (history cleared).
- Preload `frame_cnt` path by 65536 accepted frames → wraps to 0, results unaffected.
